// File: rtl/tff_sync_counter_pkg.sv
// tff_sync_counter_pkg: shared direction constants and load clamping helper for the T-cell counter.
package tff_sync_counter_pkg;
   localparam logic CNT_UP = 1'b1;
   localparam logic CNT_DN = 1'b0;
   function automatic logic [31:0] clamp_to_max(input logic [31:0] val, input logic [31:0] max);
      return (val > max) ? max : val;
   endfunction
endpackage

// File: rtl/tff_sync_counter_tff_cell.sv
// tff_cell: single-bit toggle flip-flop with asynchronous active-high reset to 0.
module tff_cell (
   input  logic clk,
   input  logic reset,
   input  logic t,
   output logic q
);
   logic q_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) q_q <= 1'b0;
      else       q_q <= q_q ^ t;
   end
   assign q = q_q;
endmodule

// File: rtl/tff_sync_counter.sv
// tff_sync_counter: modulus up/down counter with load, clear and wrap/saturate, built from T cells.
module tff_sync_counter
   import tff_sync_counter_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int MAX_COUNT = 2**WIDTH-1,
   parameter int SATURATE  = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clear,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             ovf
);
   localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_COUNT);
   localparam bit               SAT = (SATURATE != 0);
   logic [WIDTH-1:0] q_q, q_d, t, cnt, ld;
   logic             at_max, at_zero, up, ovf_q, ovf_d;
   assign up      = (up_dn == CNT_UP);
   assign at_max  = (q_q == MAX);
   assign at_zero = (q_q == '0);
   assign tc      = en & (up ? at_max : at_zero);
   assign ld      = WIDTH'(clamp_to_max(32'(load_val), 32'(MAX_COUNT)));
   always_comb begin
      cnt   = up ? (at_max ? (SAT ? q_q : '0) : q_q + WIDTH'(1))
                 : (at_zero ? (SAT ? q_q : MAX) : q_q - WIDTH'(1));
      q_d   = clear ? '0 : load ? ld : en ? cnt : q_q;
      ovf_d = !clear && !load && tc;
      t     = q_q ^ q_d;
   end
   // every bit, including load and clear targets, is reached by toggling its cell
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      tff_cell u_cell (
         .clk   (clk),
         .reset (reset),
         .t     (t[i]),
         .q     (q_q[i])
      );
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) ovf_q <= 1'b0;
      else       ovf_q <= ovf_d;
   end
   assign q   = q_q;
   assign ovf = ovf_q;
endmodule

// File: tb/tb_tff_sync_counter.sv
// tb_tff_sync_counter: three counter configurations driven in lockstep and checked against an integer model.
module tb_tff_sync_counter;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en = 1'b0, up_dn = 1'b1, load = 1'b0, clear = 1'b0;
   logic [3:0] load_val = '0;
   logic [3:0] q0, q1;
   logic [2:0] q2;
   logic [2:0] tcv, ovfv;
   logic [3:0] qa [3];
   int         n_checks = 0, n_err = 0;
   int         mq [3], mo [3];
   localparam int MX  [3] = '{9, 9, 7};
   localparam int SAT [3] = '{0, 1, 0};
   localparam int WD  [3] = '{4, 4, 3};

   always #5 clk = ~clk;

   tff_sync_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(0)) u_wrap (
      .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
      .clear(clear), .q(q0), .tc(tcv[0]), .ovf(ovfv[0]));
   tff_sync_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1)) u_sat (
      .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
      .clear(clear), .q(q1), .tc(tcv[1]), .ovf(ovfv[1]));
   tff_sync_counter #(.WIDTH(3), .MAX_COUNT(7), .SATURATE(0)) u_w3 (
      .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val[2:0]),
      .clear(clear), .q(q2), .tc(tcv[2]), .ovf(ovfv[2]));

   assign qa[0] = q0;
   assign qa[1] = q1;
   assign qa[2] = {1'b0, q2};

   task automatic chk(input string tag, input int d, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s dut%0d: observed %0d expected %0d", tag, d, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         mq[d] = 0;
         mo[d] = 0;
      end
   endtask

   // one clock edge: tc is checked before the edge, q/ovf just after it
   task automatic step(input logic e, input logic u, input logic l, input logic c, input logic [3:0] v);
      int lv, at_bound;
      en = e; up_dn = u; load = l; clear = c; load_val = v;
      #1;
      for (int d = 0; d < 3; d++) begin
         at_bound = (u ? (mq[d] == MX[d]) : (mq[d] == 0)) ? 1 : 0;
         chk("tc", d, int'(tcv[d]), e ? at_bound : 0);
      end
      @(posedge clk);
      for (int d = 0; d < 3; d++) begin
         lv = int'(v) % (1 << WD[d]);
         if (c) begin
            mq[d] = 0; mo[d] = 0;
         end else if (l) begin
            mq[d] = (lv > MX[d]) ? MX[d] : lv; mo[d] = 0;
         end else if (e && u) begin
            mo[d] = (mq[d] == MX[d]) ? 1 : 0;
            mq[d] = (mq[d] < MX[d]) ? mq[d] + 1 : (SAT[d] != 0 ? mq[d] : 0);
         end else if (e) begin
            mo[d] = (mq[d] == 0) ? 1 : 0;
            mq[d] = (mq[d] > 0) ? mq[d] - 1 : (SAT[d] != 0 ? mq[d] : MX[d]);
         end else begin
            mo[d] = 0;
         end
      end
      #1;
      for (int d = 0; d < 3; d++) begin
         chk("q", d, int'(qa[d]), mq[d]);
         chk("ovf", d, int'(ovfv[d]), mo[d]);
      end
   endtask

   initial begin
      model_reset();
      #2;
      for (int d = 0; d < 3; d++) begin
         chk("rst_q", d, int'(qa[d]), 0);
         chk("rst_ovf", d, int'(ovfv[d]), 0);
      end
      #5 reset = 1'b0;
      for (int i = 0; i < 11; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 4'd12);
      step(1'b1, 1'b1, 1'b1, 1'b0, 4'd3);
      step(1'b1, 1'b1, 1'b1, 1'b1, 4'd7);
      step(1'b0, 1'b1, 1'b1, 1'b0, 4'd9);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 4'd5);
      step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      #2 reset = 1'b1;
      #1;
      model_reset();
      for (int d = 0; d < 3; d++) begin
         chk("async_q", d, int'(qa[d]), 0);
         chk("async_ovf", d, int'(ovfv[d]), 0);
      end
      #1 reset = 1'b0;
      step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 4'd7);
      for (int i = 0; i < 4; i++) step(1'b0, 1'(i), 1'b0, 1'b0, 4'd0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 4) != 0, 1'($urandom), $urandom_range(0, 15) == 0,
              $urandom_range(0, 24) == 0, 4'($urandom));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
